// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: turns EXE-stage adder flags (rs1 - rs2) into a RISC-V
// branch/jump decision and redirect target, and drives a multi-cycle front-end
// flush under a predict-not-taken policy. All outputs are registered.
module branch_resolve_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            N,
    input  logic            Z,
    input  logic            C,
    input  logic            V,
    output logic            out_valid,
    output logic            taken,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] link_val,
    output logic            flush,
    output logic            misalign,
    output logic            illegal
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t          state, state_next;
    logic [3:0]      cnt, cnt_next;

    logic            sel_jalr_p0, sel_jal_p0, sel_br_p0;
    logic            illegal_p0, take_p0, mis_p0, accept_p0;
    logic [XLEN-1:0] pc_sum_p0, jalr_sum_p0, target_p0, link_p0;

    // Branch condition from the subtract flags; C is carry-out of a+~b+1,
    // so C=1 means rs1 >= rs2 unsigned. Reserved encodings never take.
    function automatic logic branch_cond(input logic [2:0] f,
                                         input logic n, input logic z,
                                         input logic c, input logic v);
        case (f)
            3'b000:  return z;
            3'b001:  return ~z;
            3'b100:  return n ^ v;
            3'b101:  return ~(n ^ v);
            3'b110:  return ~c;
            3'b111:  return c;
            default: return 1'b0;
        endcase
    endfunction

    // Decode: type priority jalr > jal > branch, target and link computation
    always_comb begin
        sel_jalr_p0 = is_jalr;
        sel_jal_p0  = ~is_jalr & is_jal;
        sel_br_p0   = ~is_jalr & ~is_jal & is_branch;
        illegal_p0  = sel_br_p0 & (funct3[2:1] == 2'b01);
        pc_sum_p0   = pc + imm;
        jalr_sum_p0 = rs1_val + imm;
        target_p0   = sel_jalr_p0 ? {jalr_sum_p0[XLEN-1:1], 1'b0} : pc_sum_p0;
        link_p0     = pc + XLEN'(4);
        take_p0     = sel_jalr_p0 | sel_jal_p0 |
                      (sel_br_p0 & branch_cond(funct3, N, Z, C, V));
        mis_p0      = take_p0 & target_p0[1];
        accept_p0   = in_valid & (state == IDLE);
    end

    // Next-state logic: aligned taken enters FLUSH, counter runs down to IDLE
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept_p0 && take_p0 && !mis_p0) begin
                    state_next = FLUSH;
                    cnt_next   = CNT_INIT;
                end
            end
            FLUSH: begin
                if (cnt == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // State and flush counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Registered decision outputs; redirect_pc only moves on a taken decision
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            taken       <= 1'b0;
            redirect    <= 1'b0;
            misalign    <= 1'b0;
            illegal     <= 1'b0;
            flush       <= 1'b0;
            redirect_pc <= '0;
            link_val    <= '0;
        end else begin
            out_valid <= accept_p0;
            taken     <= accept_p0 & take_p0;
            redirect  <= accept_p0 & take_p0 & ~mis_p0;
            misalign  <= accept_p0 & mis_p0;
            illegal   <= accept_p0 & illegal_p0;
            flush     <= (state_next == FLUSH);
            if (accept_p0) begin
                link_val <= link_p0;
            end
            if (accept_p0 && take_p0) begin
                redirect_pc <= target_p0;
            end
        end
    end

endmodule
